// File: rtl/search_controller.sv
// Iterative-deepening search sequencer between uci_handler and the engine core.
// Runs depths 1..MAX_DEPTH, enforces a cycle budget and stop, and emits ASCII info and the best move.
module search_controller #(
  parameter int MAX_DEPTH   = 6,
  parameter int TIME_BUDGET = 100000000,
  parameter int TIMER_W     = 32,
  parameter int INFO_LEN    = 52,
  parameter int BOARD_W     = 256,
  parameter int MOVE_W      = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [BOARD_W-1:0]      board_in,
  input  logic                    board_in_valid,
  input  logic                    go_in,
  input  logic                    stop_in,
  output logic [BOARD_W-1:0]      engine_board_out,
  output logic [3:0]              engine_depth_out,
  output logic                    engine_start_out,
  output logic                    engine_abort_out,
  input  logic                    engine_done_in,
  input  logic                    engine_aborted_in,
  input  logic [MOVE_W-1:0]       engine_move_in,
  input  logic signed [15:0]      engine_score_in,
  output logic [8*INFO_LEN-1:0]   info_out,
  output logic                    info_valid,
  input  logic                    info_ready,
  output logic [MOVE_W-1:0]       best_move_out,
  output logic                    best_move_valid,
  input  logic                    best_move_ready,
  output logic                    busy_out
);

  typedef enum logic [2:0] {IDLE, RUN, FMT, BUILD, INFO, BEST} state_t;

  localparam logic [47:0] PFX_DEPTH = "depth ";
  localparam logic [79:0] PFX_SCORE = " score cp ";

  state_t                state_q, state_d;
  logic [3:0]            depth_q, depth_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic                  time_up_q, time_up_d;
  logic [BOARD_W-1:0]    shadow_q, shadow_d;
  logic [BOARD_W-1:0]    eng_board_q, eng_board_d;
  logic                  start_q, start_d;
  logic                  abort_q, abort_d;
  logic [MOVE_W-1:0]     move_q, move_d;
  logic                  neg_q, neg_d;
  logic [15:0]           bin_q, bin_d;
  logic [19:0]           bcd_q, bcd_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [8*INFO_LEN-1:0] info_q, info_d;
  logic                  info_valid_q, info_valid_d;
  logic [MOVE_W-1:0]     best_q, best_d;
  logic                  best_valid_q, best_valid_d;

  // -32768 has no positive twin in 16 bits, so it prints as 32767.
  function automatic logic [15:0] sat_abs(input logic signed [15:0] s);
    if (s == 16'sh8000) return 16'd32767;
    else if (s < 0)     return $unsigned(-s);
    else                return $unsigned(s);
  endfunction

  function automatic logic [35:0] dd_step(input logic [19:0] bcd, input logic [15:0] bin);
    logic [19:0] b;
    b = bcd;
    for (int k = 0; k < 5; k++)
      if (b[4*k+:4] >= 4'd5) b[4*k+:4] = b[4*k+:4] + 4'd3;
    return {b, bin} << 1;
  endfunction

  function automatic logic [8*INFO_LEN-1:0] build_info(input logic [3:0] d, input logic neg,
                                                       input logic [19:0] bcd);
    logic [8*INFO_LEN-1:0] s;
    int                    p;
    logic                  started;
    logic [3:0]            dig;
    s = '0;
    for (int i = 0; i < 6; i++)  s[8*i+:8] = PFX_DEPTH[8*(5-i)+:8];
    s[48+:8] = {4'h3, d};
    for (int i = 0; i < 10; i++) s[8*(7+i)+:8] = PFX_SCORE[8*(9-i)+:8];
    p = 17;
    if (neg) begin
      s[8*p+:8] = 8'h2D;
      p = p + 1;
    end
    started = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      dig = bcd[4*k+:4];
      if (dig != 4'd0 || started || k == 0) begin
        s[8*p+:8] = {4'h3, dig};
        p = p + 1;
        started = 1'b1;
      end
    end
    return s;
  endfunction

  always_comb begin
    state_d      = state_q;
    depth_d      = depth_q;
    shadow_d     = board_in_valid ? board_in : shadow_q;
    eng_board_d  = eng_board_q;
    start_d      = 1'b0;
    move_d       = move_q;
    neg_d        = neg_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    info_d       = info_q;
    info_valid_d = info_valid_q;
    best_d       = best_q;
    best_valid_d = best_valid_q;
    timer_d      = (state_q == IDLE) ? timer_q : timer_q + TIMER_W'(1);
    time_up_d    = (state_q == IDLE) ? time_up_q
                 : (time_up_q | stop_in | (timer_d == TIMER_W'(TIME_BUDGET - 1)));

    case (state_q)
      IDLE: if (go_in) begin
        state_d     = RUN;
        depth_d     = 4'd1;
        timer_d     = '0;
        time_up_d   = 1'b0;
        eng_board_d = shadow_q;
        start_d     = 1'b1;
      end
      RUN: if (engine_done_in) begin
        if (!engine_aborted_in) begin
          move_d  = engine_move_in;
          neg_d   = engine_score_in[15];
          bin_d   = sat_abs(engine_score_in);
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = FMT;
        end else begin
          // A cut-short depth 1 is still better than no move at all.
          if (depth_q == 4'd1) move_d = engine_move_in;
          best_d       = (depth_q == 4'd1) ? engine_move_in : move_q;
          best_valid_d = 1'b1;
          state_d      = BEST;
        end
      end
      FMT: begin
        {bcd_d, bin_d} = dd_step(bcd_q, bin_q);
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = BUILD;
      end
      BUILD: begin
        info_d       = build_info(depth_q, neg_q, bcd_q);
        info_valid_d = 1'b1;
        state_d      = INFO;
      end
      INFO: if (info_ready) begin
        info_valid_d = 1'b0;
        if (depth_q == 4'(MAX_DEPTH) || time_up_d) begin
          best_d       = move_q;
          best_valid_d = 1'b1;
          state_d      = BEST;
        end else begin
          depth_d = depth_q + 4'd1;
          start_d = 1'b1;
          state_d = RUN;
        end
      end
      BEST: if (best_move_ready) begin
        best_valid_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    abort_d = (state_d == RUN) && time_up_d;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      depth_q      <= '0;
      timer_q      <= '0;
      time_up_q    <= 1'b0;
      shadow_q     <= '0;
      eng_board_q  <= '0;
      start_q      <= 1'b0;
      abort_q      <= 1'b0;
      move_q       <= '0;
      neg_q        <= 1'b0;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      info_q       <= '0;
      info_valid_q <= 1'b0;
      best_q       <= '0;
      best_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      depth_q      <= depth_d;
      timer_q      <= timer_d;
      time_up_q    <= time_up_d;
      shadow_q     <= shadow_d;
      eng_board_q  <= eng_board_d;
      start_q      <= start_d;
      abort_q      <= abort_d;
      move_q       <= move_d;
      neg_q        <= neg_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      info_q       <= info_d;
      info_valid_q <= info_valid_d;
      best_q       <= best_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign engine_board_out = eng_board_q;
  assign engine_depth_out = depth_q;
  assign engine_start_out = start_q;
  assign engine_abort_out = abort_q;
  assign info_out         = info_q;
  assign info_valid       = info_valid_q;
  assign best_move_out    = best_q;
  assign best_move_valid  = best_valid_q;
  assign busy_out         = (state_q != IDLE);

endmodule

// File: tb/tb_search_controller.sv
// Directed bench for search_controller: table-driven full search plus timeout, stop, board and reset sequences.
module tb_search_controller;
  localparam int MAX_DEPTH = 6;
  localparam int TBUDGET   = 1000;
  localparam int INFO_LEN  = 52;
  localparam int BOARD_W   = 64;
  localparam int MOVE_W    = 16;
  localparam int IW        = 8 * INFO_LEN;

  logic               clk = 1'b0;
  logic               rst_in = 1'b1;
  logic [BOARD_W-1:0] board_in = '0;
  logic               board_in_valid = 1'b0;
  logic               go_in = 1'b0, stop_in = 1'b0;
  logic [BOARD_W-1:0] engine_board_out;
  logic [3:0]         engine_depth_out;
  logic               engine_start_out, engine_abort_out;
  logic               engine_done_in = 1'b0, engine_aborted_in = 1'b0;
  logic [MOVE_W-1:0]  engine_move_in = '0;
  logic signed [15:0] engine_score_in = '0;
  logic [IW-1:0]      info_out;
  logic               info_valid;
  logic               info_ready = 1'b0;
  logic [MOVE_W-1:0]  best_move_out;
  logic               best_move_valid;
  logic               best_move_ready = 1'b0;
  logic               busy_out;

  search_controller #(.MAX_DEPTH(MAX_DEPTH), .TIME_BUDGET(TBUDGET), .TIMER_W(32),
                      .INFO_LEN(INFO_LEN), .BOARD_W(BOARD_W), .MOVE_W(MOVE_W)) dut (
    .clk_in(clk), .rst_in(rst_in), .board_in(board_in), .board_in_valid(board_in_valid),
    .go_in(go_in), .stop_in(stop_in), .engine_board_out(engine_board_out),
    .engine_depth_out(engine_depth_out), .engine_start_out(engine_start_out),
    .engine_abort_out(engine_abort_out), .engine_done_in(engine_done_in),
    .engine_aborted_in(engine_aborted_in), .engine_move_in(engine_move_in),
    .engine_score_in(engine_score_in), .info_out(info_out), .info_valid(info_valid),
    .info_ready(info_ready), .best_move_out(best_move_out), .best_move_valid(best_move_valid),
    .best_move_ready(best_move_ready), .busy_out(busy_out));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, n_start = 0, n_info = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (engine_start_out) n_start <= n_start + 1;
    if (info_valid && info_ready) n_info <= n_info + 1;
  end

  typedef struct {
    logic signed [15:0] score;
    logic [15:0]        move;
    string              exp;
  } vec_t;
  vec_t vecs[6];

  task automatic set_vec(input int i, input logic signed [15:0] sc, input logic [15:0] mv,
                         input string e);
    vecs[i].score = sc;
    vecs[i].move  = mv;
    vecs[i].exp   = e;
  endtask

  function automatic logic [IW-1:0] str2info(input string s);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[8*i+:8] = s[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic check_info(input string name, input logic [IW-1:0] got, input logic [IW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output bit ok);
    int k = 0;
    while (!engine_start_out && k < 60) begin tick(); k++; end
    ok = engine_start_out;
  endtask

  task automatic wait_info(output int k);
    k = 0;
    while (!info_valid && k < 60) begin tick(); k++; end
  endtask

  task automatic wait_best(output bit ok);
    int k = 0;
    while (!best_move_valid && k < 60) begin tick(); k++; end
    ok = best_move_valid;
  endtask

  task automatic pulse_done(input logic ab, input logic [15:0] mv, input logic signed [15:0] sc);
    engine_done_in = 1'b1; engine_aborted_in = ab; engine_move_in = mv; engine_score_in = sc;
    tick();
    engine_done_in = 1'b0; engine_aborted_in = 1'b0;
  endtask

  task automatic do_go(output int gc);
    go_in = 1'b1;
    tick();
    go_in = 1'b0;
    gc = cyc;
  endtask

  task automatic take_best();
    best_move_ready = 1'b1;
    tick();
    best_move_ready = 1'b0;
    check("idle_after_best", {62'd0, busy_out, best_move_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int k, gc, s0, i0;
    logic [IW-1:0] snap;
    bit stable;

    set_vec(0, 16'sd0,      16'h0101, "depth 1 score cp 0");
    set_vec(1, 16'sd37,     16'h0202, "depth 2 score cp 37");
    set_vec(2, -16'sd125,   16'h0303, "depth 3 score cp -125");
    set_vec(3, 16'sh8000,   16'h0404, "depth 4 score cp -32767");
    set_vec(4, 16'sd32767,  16'h0505, "depth 5 score cp 32767");
    set_vec(5, 16'sd1005,   16'h0606, "depth 6 score cp 1005");

    tick(); tick();
    check("rst_ctrl", {58'd0, busy_out, info_valid, best_move_valid, engine_start_out,
                       engine_abort_out, 1'b0}, 64'd0);
    check("rst_depth", engine_depth_out, 64'd0);
    check("rst_board", engine_board_out, 64'd0);
    check("rst_best", best_move_out, 64'd0);
    check_info("rst_info", info_out, '0);
    rst_in = 1'b0;
    tick();
    stop_in = 1'b1; tick(); stop_in = 1'b0;
    check("stop_in_idle", {62'd0, busy_out, engine_abort_out}, 64'd0);

    // Full six-depth search driven from the vector table.
    board_in = 64'hA1A1_A1A1_A1A1_A1A1; board_in_valid = 1'b1; tick(); board_in_valid = 1'b0;
    s0 = n_start; i0 = n_info;
    do_go(gc);
    check("go_board", engine_board_out, 64'hA1A1_A1A1_A1A1_A1A1);
    check("go_busy", busy_out, 64'd1);
    for (int i = 0; i < 6; i++) begin
      wait_start(ok);
      check("start_seen", ok, 64'd1);
      check("start_depth", engine_depth_out, i + 1);
      tick(); tick(); tick();
      pulse_done(1'b0, vecs[i].move, vecs[i].score);
      wait_info(k);
      check("info_latency", k, 64'd17);
      check_info("info_str", info_out, str2info(vecs[i].exp));
      if (i == 2) begin
        snap = info_out; stable = 1'b1; k = n_start;
        for (int j = 0; j < 50; j++) begin
          tick();
          if (info_out !== snap || !info_valid || engine_start_out) stable = 1'b0;
        end
        check("info_hold", stable, 64'd1);
        check("no_start_while_held", n_start, k);
      end
      info_ready = 1'b1; tick(); info_ready = 1'b0;
      check("info_drop", info_valid, 64'd0);
    end
    wait_best(ok);
    check("best_seen", ok, 64'd1);
    check("best_move_full", best_move_out, 64'h0606);
    check("start_count", n_start - s0, 64'd6);
    check("info_count", n_info - i0, 64'd6);
    stable = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (!best_move_valid || best_move_out !== 16'h0606) stable = 1'b0;
    end
    check("best_hold", stable, 64'd1);
    take_best();

    // Budget expiry while depth 2 never finishes.
    i0 = n_info;
    do_go(gc);
    wait_start(ok);
    tick(); tick();
    pulse_done(1'b0, 16'hAAAA, 16'sd50);
    wait_info(k);
    check_info("info_d1_timeout", info_out, str2info("depth 1 score cp 50"));
    info_ready = 1'b1; tick(); info_ready = 1'b0;
    wait_start(ok);
    check("d2_start", engine_depth_out, 64'd2);
    while (cyc < gc + 998) tick();
    check("abort_before_budget", engine_abort_out, 64'd0);
    tick();
    check("abort_at_budget", engine_abort_out, 64'd1);
    tick(); tick();
    pulse_done(1'b1, 16'hBBBB, 16'sd0);
    check("abort_released", engine_abort_out, 64'd0);
    wait_best(ok);
    check("best_timeout", best_move_out, 64'hAAAA);
    check("info_timeout_count", n_info - i0, 64'd1);
    take_best();

    // Stop during depth 1.
    i0 = n_info;
    do_go(gc);
    wait_start(ok);
    tick(); tick();
    stop_in = 1'b1; tick(); stop_in = 1'b0;
    check("abort_on_stop", engine_abort_out, 64'd1);
    pulse_done(1'b1, 16'hCCCC, 16'sd10);
    wait_best(ok);
    check("best_stop", best_move_out, 64'hCCCC);
    check("info_stop_count", n_info - i0, 64'd0);
    take_best();

    // Board arriving mid-search and a second go while busy.
    board_in = 64'h1111_2222_3333_4444; board_in_valid = 1'b1; tick(); board_in_valid = 1'b0;
    do_go(gc);
    wait_start(ok);
    board_in = 64'h5555_6666_7777_8888; board_in_valid = 1'b1; tick(); board_in_valid = 1'b0;
    check("board_mid_search", engine_board_out, 64'h1111_2222_3333_4444);
    s0 = n_start;
    go_in = 1'b1; tick(); go_in = 1'b0;
    tick(); tick();
    check("second_go_start", n_start, s0);
    check("second_go_depth", engine_depth_out, 64'd1);
    stop_in = 1'b1; tick(); stop_in = 1'b0;
    pulse_done(1'b1, 16'hDDDD, 16'sd0);
    wait_best(ok);
    take_best();
    do_go(gc);
    check("board_next_go", engine_board_out, 64'h5555_6666_7777_8888);

    // Reset in the middle of a search.
    stop_in = 1'b1; tick(); stop_in = 1'b0;
    check("abort_pre_reset", engine_abort_out, 64'd1);
    #2 rst_in = 1'b1;
    #1;
    check("reset_mid_search", {62'd0, busy_out, engine_abort_out}, 64'd0);
    tick();
    rst_in = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
